fifo_occupancy_monitor: RTL

FIFO_OCCUPANCY_MONITOR -- requirements
Module: fifo_occupancy_monitor

---
 rtl/fifo_occupancy_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_occupancy_monitor.sv
// fifo_occupancy_monitor
// Tracks occupancy of five FIFOs (MF, VC0, VC1, D0, D1) from their push/pop
// strobes. It drives registered empty, full, almost-full and almost-empty
// flags, plus an overflow/underflow error flag for each FIFO.
// The flags come from the post-update counter, so they appear one cycle after
// the strobe edge.
// Build option FIFO_MON_STICKY_ERR_EN:
//   - defined: each error bit stays set until init or reset.
//   - undefined: each error bit is a one-cycle pulse.
// Reset is synchronous and active-low.
module fifo_occupancy_monitor #(
  parameter int DEPTH    = 8,
  parameter int CW       = 4,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [4:0]    push,
  input  logic [4:0]    pop,
  input  logic [CW-1:0] umbral_mf,
  input  logic [CW-1:0] umbral_vc0,
  input  logic [CW-1:0] umbral_vc1,
  input  logic [CW-1:0] umbral_d0,
  input  logic [CW-1:0] umbral_d1,
  output logic [4:0]    fifo_empties,
  output logic [4:0]    fifo_full,
  output logic [4:0]    almost_full,
  output logic [4:0]    almost_empty,
  output logic [4:0]    fifo_errors
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Thresholds gathered into an array so the per-FIFO logic can be generated.
  logic [CW-1:0] umbral_in [5];
  assign umbral_in[0] = umbral_mf;
  assign umbral_in[1] = umbral_vc0;
  assign umbral_in[2] = umbral_vc1;
  assign umbral_in[3] = umbral_d0;
  assign umbral_in[4] = umbral_d1;

  // Next-state flag vectors, computed per FIFO.
  logic [4:0] empty_next;
  logic [4:0] full_next;
  logic [4:0] af_next;
  logic [4:0] ae_next;
  logic [4:0] err_evt;
  logic [4:0] err_next;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_fifo
      logic [CW-1:0] count_reg, count_next;
      logic [CW-1:0] thr_reg, thr_next;
      logic [CW-1:0] thr_eff;
      logic          err_local;

      // Update the counter and threshold from init and the strobe pair.
      // Underflow and overflow saturate the counter instead of wrapping.
      always_comb begin
        count_next = count_reg;
        thr_next   = thr_reg;
        err_local  = 1'b0;
        if (init) begin
          thr_next   = umbral_in[gi];
          count_next = '0;
        end else begin
          case ({push[gi], pop[gi]})
            2'b10: begin
              if (count_reg < DEPTH_C) count_next = count_reg + ONE_C;
              else                     err_local  = 1'b1;
            end
            2'b01: begin
              if (count_reg != '0) count_next = count_reg - ONE_C;
              else                 err_local  = 1'b1;
            end
            2'b11: begin
              // At zero the pop has nothing to read, but the push still lands.
              if (count_reg == '0) begin
                count_next = ONE_C;
                err_local  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      // Treat a zero or out-of-range threshold as DEPTH.
      assign thr_eff = ((thr_next == '0) || (thr_next > DEPTH_C)) ? DEPTH_C : thr_next;

      assign empty_next[gi] = (count_next == '0);
      assign full_next[gi]  = (count_next == DEPTH_C);
      assign af_next[gi]    = (count_next >= thr_eff);
      assign ae_next[gi]    = (count_next <= AE_C);
      assign err_evt[gi]    = err_local;

      // Register the occupancy and the latched threshold.
      always_ff @(posedge clk) begin
        if (!reset) begin
          count_reg <= '0;
          thr_reg   <= DEPTH_C;
        end else begin
          count_reg <= count_next;
          thr_reg   <= thr_next;
        end
      end
    end
  endgenerate

  // Choose the next error value for the sticky or the pulsed build.
  always_comb begin
`ifdef FIFO_MON_STICKY_ERR_EN
    err_next = init ? 5'b00000 : (fifo_errors | err_evt);
`else
    err_next = err_evt;
`endif
  end

  // Register all status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_empties <= 5'b11111;
      fifo_full    <= 5'b00000;
      almost_full  <= 5'b00000;
      almost_empty <= 5'b11111;
      fifo_errors  <= 5'b00000;
    end else begin
      fifo_empties <= empty_next;
      fifo_full    <= full_next;
      almost_full  <= af_next;
      almost_empty <= ae_next;
      fifo_errors  <= err_next;
    end
  end

endmodule
